alu_cmd_encoder: RTL

ALU_CMD_ENCODER -- requirements
Module: alu_cmd_encoder

---
 rtl/alu_pkg.sv | 27 ++
 rtl/rr_arbiter4.sv | 48 ++++
 rtl/alu_cmd_encoder.sv | 126 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command definitions: class codes, ALU_FUN field layout and default operand width.
// Used by both the command encoder and the ALU decoder so the two can never disagree.
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    CLS_ARITH = 2'b00,
    CLS_LOGIC = 2'b01,
    CLS_CMP   = 2'b10,
    CLS_SHIFT = 2'b11
  } alu_class_e;

  localparam int FUN_CLS_HI = 3;
  localparam int FUN_CLS_LO = 2;
  localparam int FUN_OP_HI  = 1;
  localparam int FUN_OP_LO  = 0;

  function automatic logic [3:0] make_fun(input logic [1:0] cls, input logic [1:0] op);
    logic [3:0] f;
    f = '0;
    f[FUN_CLS_HI:FUN_CLS_LO] = cls;
    f[FUN_OP_HI:FUN_OP_LO]   = op;
    return f;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter. The search starts at the pointer; the pointer moves
// one past the winner whenever a grant is issued and holds otherwise.
module rr_arbiter4 (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       en,
  output logic [3:0] gnt,
  output logic [1:0] win,
  output logic [1:0] ptr
);

  logic [1:0] ptr_q;
  logic [1:0] ptr_d;
  logic       found;
  logic [1:0] idx;

  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    idx   = ptr_q;
    for (int i = 0; i < 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (en && found) gnt[win] = 1'b1;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (|gnt) ptr_d = win + 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 2'd0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/alu_cmd_encoder.sv
// Arbitrates four ALU request classes into one registered ALU command stream.
// Output handshake: a command moves on a cycle with Out_Valid && Out_Ready; Out_Valid holds with a stable payload until then.
module alu_cmd_encoder
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Arith_Req,
  input  logic             Logic_Req,
  input  logic             CMP_Req,
  input  logic             Shift_Req,
  input  logic [1:0]       Arith_Op,
  input  logic [1:0]       Logic_Op,
  input  logic [1:0]       CMP_Op,
  input  logic [1:0]       Shift_Op,
  input  logic [WIDTH-1:0] Arith_A,
  input  logic [WIDTH-1:0] Arith_B,
  input  logic [WIDTH-1:0] Logic_A,
  input  logic [WIDTH-1:0] Logic_B,
  input  logic [WIDTH-1:0] CMP_A,
  input  logic [WIDTH-1:0] CMP_B,
  input  logic [WIDTH-1:0] Shift_A,
  input  logic [WIDTH-1:0] Shift_B,
  output logic             Arith_Gnt,
  output logic             Logic_Gnt,
  output logic             CMP_Gnt,
  output logic             Shift_Gnt,
  output logic [3:0]       ALU_FUN,
  output logic [WIDTH-1:0] ALU_A,
  output logic [WIDTH-1:0] ALU_B,
  output logic             Out_Valid,
  input  logic             Out_Ready,
  output logic [7:0]       Issue_Cnt,
  output logic [1:0]       dbg_ptr
);

  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       win;
  logic             stage_free;
  logic             transfer;
  logic             accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;

  logic [3:0]       fun_q, fun_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;
  logic [7:0]       cnt_q, cnt_d;

  assign req        = {Shift_Req, CMP_Req, Logic_Req, Arith_Req};
  assign stage_free = !valid_q || Out_Ready;
  assign accept     = valid_q && Out_Ready;
  assign transfer   = |gnt;

  // Reset gates the arbiter so nothing is granted while the pipeline is being cleared.
  rr_arbiter4 u_arb (
    .clk (CLK),
    .rst (RST),
    .req (req),
    .en  (stage_free && !RST),
    .gnt (gnt),
    .win (win),
    .ptr (dbg_ptr)
  );

  always_comb begin
    op_sel = Arith_Op;
    a_sel  = Arith_A;
    b_sel  = Arith_B;
    unique case (win)
      CLS_ARITH: begin op_sel = Arith_Op; a_sel = Arith_A; b_sel = Arith_B; end
      CLS_LOGIC: begin op_sel = Logic_Op; a_sel = Logic_A; b_sel = Logic_B; end
      CLS_CMP:   begin op_sel = CMP_Op;   a_sel = CMP_A;   b_sel = CMP_B;   end
      CLS_SHIFT: begin op_sel = Shift_Op; a_sel = Shift_A; b_sel = Shift_B; end
      default:   begin op_sel = Arith_Op; a_sel = Arith_A; b_sel = Arith_B; end
    endcase
  end

  always_comb begin
    fun_d   = fun_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = valid_q;
    cnt_d   = cnt_q + 8'(accept);
    if (transfer) begin
      fun_d   = make_fun(win, op_sel);
      a_d     = a_sel;
      b_d     = b_sel;
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      fun_q   <= 4'b0000;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      fun_q   <= fun_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Arith_Gnt = gnt[CLS_ARITH];
  assign Logic_Gnt = gnt[CLS_LOGIC];
  assign CMP_Gnt   = gnt[CLS_CMP];
  assign Shift_Gnt = gnt[CLS_SHIFT];
  assign ALU_FUN   = fun_q;
  assign ALU_A     = a_q;
  assign ALU_B     = b_q;
  assign Out_Valid = valid_q;
  assign Issue_Cnt = cnt_q;

endmodule
